// File: rtl/reg_bank_pkg.sv
// Shared defaults and FSM encoding for the two-requester register bank arbiter.
package reg_bank_pkg;

  localparam int DATA_W_DEF   = 4;
  localparam int NUM_REGS_DEF = 4;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  // Each grant owns one state bit, so gnt0/gnt1 are straight register outputs.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

endpackage

// File: rtl/reg_bank.sv
// Register array with a single write port and a registered read port.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] bank [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (we) begin
      bank[waddr] <= wdata;
    end
  end

  // Reads sample the array before this edge's write lands: same-address collisions return the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= bank[raddr];
  end

endmodule

// File: rtl/reg_bank_arb.sv
// Round-robin arbiter granting two writers single-cycle access to a shared register bank.
module reg_bank_arb
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        wr_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic              last;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // last = 1 after reset so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == G0)      last <= 1'b0;
      else if (state_nxt == G1) last <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (!clr) begin
      case (state)
        IDLE: begin
          if (req0 && req1) state_nxt = last ? G0 : G1;
          else if (req0)    state_nxt = G0;
          else if (req1)    state_nxt = G1;
        end
        G0:      if (req1) state_nxt = G1;
        G1:      if (req0) state_nxt = G0;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The write commits on the same edge that raises the grant.
  always_comb begin
    gnt0  = (state == G0);
    gnt1  = (state == G1);
    we    = (state_nxt != IDLE);
    waddr = (state_nxt == G1) ? addr1 : addr0;
    wdata = (state_nxt == G1) ? data1 : data0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     wr_cnt <= 8'd0;
    else if (clr)                   wr_cnt <= 8'd0;
    else if (we && wr_cnt != 8'hFF) wr_cnt <= wr_cnt + 8'd1;
  end

  reg_bank #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_reg_bank_arb.sv
// Directed bench for reg_bank_arb: grants, round-robin, read collision, clear, saturation, async reset.
module tb_reg_bank_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       req0, req1;
  logic [1:0] addr0, addr1, raddr;
  logic [3:0] data0, data1;
  logic       gnt0, gnt1;
  logic [3:0] rdata;
  logic [7:0] wr_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_bank_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .req0  (req0),
    .addr0 (addr0),
    .data0 (data0),
    .req1  (req1),
    .addr1 (addr1),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .raddr (raddr),
    .rdata (rdata),
    .wr_cnt(wr_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; raddr = '0;
    step(); step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b00) begin
      miscompares++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1});
    end
    vectors++;
    if (wr_cnt !== 8'd0) begin
      miscompares++; $display("FAIL reset_wr_cnt: got %0d expected 0", wr_cnt);
    end
    vectors++;
    if (rdata !== 4'h0) begin
      miscompares++; $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    req0 = 1'b1; addr0 = 2'd2; data0 = 4'hA;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10 || wr_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL single_grant: gnt=%b cnt=%0d expected gnt=10 cnt=1", {gnt0, gnt1}, wr_cnt);
    end
    req0 = 1'b0; raddr = 2'd2;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b00) begin
      miscompares++; $display("FAIL single_pulse: got %b expected 00", {gnt0, gnt1});
    end
    vectors++;
    if (rdata !== 4'hA || wr_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL single_read: rdata=%h cnt=%0d expected rdata=a cnt=1", rdata, wr_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req0 = 1'b1; addr0 = 2'd0; data0 = 4'h3;
    req1 = 1'b1; addr1 = 2'd3; data1 = 4'hC;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({gnt0, gnt1} !== exp_g[i]) begin
        miscompares++;
        $display("FAIL rr_grant_%0d: got %b expected %b", i, {gnt0, gnt1}, exp_g[i]);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b00 || wr_cnt !== 8'd4) begin
      miscompares++;
      $display("FAIL rr_idle: gnt=%b cnt=%0d expected gnt=00 cnt=4", {gnt0, gnt1}, wr_cnt);
    end
  endtask

  task automatic test_read_collision();
    req0 = 1'b1; addr0 = 2'd1; data0 = 4'h5; raddr = 2'd1;
    step();
    vectors++;
    if (rdata !== 4'h0) begin
      miscompares++; $display("FAIL collide_old: got %h expected 0", rdata);
    end
    req0 = 1'b0;
    step();
    vectors++;
    if (rdata !== 4'h5) begin
      miscompares++; $display("FAIL collide_new: got %h expected 5", rdata);
    end
  endtask

  task automatic test_clear();
    req1 = 1'b1; addr1 = 2'd2; data1 = 4'h7; clr = 1'b1;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b00 || wr_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL clr_cycle: gnt=%b cnt=%0d expected gnt=00 cnt=0", {gnt0, gnt1}, wr_cnt);
    end
    clr = 1'b0; raddr = 2'd2;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01 || wr_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL clr_release: gnt=%b cnt=%0d expected gnt=01 cnt=1", {gnt0, gnt1}, wr_cnt);
    end
    vectors++;
    if (rdata !== 4'h0) begin
      miscompares++; $display("FAIL clr_bank2: got %h expected 0", rdata);
    end
    req1 = 1'b0; raddr = 2'd1;
    step();
    vectors++;
    if (rdata !== 4'h0) begin
      miscompares++; $display("FAIL clr_bank1: got %h expected 0", rdata);
    end
    raddr = 2'd2;
    step();
    vectors++;
    if (rdata !== 4'h7) begin
      miscompares++; $display("FAIL clr_postwrite: got %h expected 7", rdata);
    end
  endtask

  task automatic test_saturation();
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 260; i++) begin
      req0 = 1'b1; addr0 = i[1:0]; data0 = i[3:0];
      step();
      req0 = 1'b0;
      step();
      if (i == 253) begin
        vectors++;
        if (wr_cnt !== 8'd254) begin
          miscompares++; $display("FAIL sat_254: got %0d expected 254", wr_cnt);
        end
      end
    end
    vectors++;
    if (wr_cnt !== 8'd255) begin
      miscompares++; $display("FAIL sat_hold: got %0d expected 255", wr_cnt);
    end
  endtask

  task automatic test_async_reset();
    req0 = 1'b1; addr0 = 2'd0; data0 = 4'h9;
    req1 = 1'b1; addr1 = 2'd1; data1 = 4'h6;
    raddr = 2'd3;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin
      miscompares++; $display("FAIL arst_pre: got %b expected 01", {gnt0, gnt1});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt0, gnt1} !== 2'b00 || wr_cnt !== 8'd0 || rdata !== 4'h0) begin
      miscompares++;
      $display("FAIL arst_immediate: gnt=%b cnt=%0d rdata=%h expected 00/0/0",
               {gnt0, gnt1}, wr_cnt, rdata);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin
      miscompares++; $display("FAIL arst_first_tie: got %b expected 10", {gnt0, gnt1});
    end
    req0 = 1'b0;
    step();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin
      miscompares++; $display("FAIL arst_second: got %b expected 01", {gnt0, gnt1});
    end
    req1 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_collision();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_bank_arb.md
REG_BANK_ARB -- requirements
Module: reg_bank_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 4: width of each bank register and of each write data port.
REQ-002 SHALL have parameter NUM_REGS, default 4: number of bank registers; ADDR_W = log2(NUM_REGS), default 2.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous clear of the bank and the write counter.
REQ-006 SHALL have port req0  input  1  write request, requester 0.
REQ-007 SHALL have port addr0  input  ADDR_W  write address, requester 0.
REQ-008 SHALL have port data0  input  DATA_W  write data, requester 0.
REQ-009 SHALL have ports req1 / addr1 / data1, same directions and widths as requester 0, for requester 1.
REQ-010 SHALL have ports gnt0, gnt1  output  1 each  registered one-cycle grant pulses.
REQ-011 SHALL have port raddr  input  ADDR_W  read address.
REQ-012 SHALL have port rdata  output  DATA_W  registered read data.
REQ-013 SHALL have port wr_cnt  output  8  saturating count of committed writes.

Function
REQ-014 SHALL implement FSM states IDLE, G0 and G1; state Gn means gnt_n is high in the current cycle.
REQ-015 SHALL hold the bank as NUM_REGS registers of DATA_W bits.
REQ-016 SHALL, at the edge entering Gn, write data_n to bank[addr_n] and increment wr_cnt; the write and the grant occur on the same edge.
REQ-017 SHALL transition from IDLE as follows: req0 only -> G0; req1 only -> G1; neither -> IDLE.
REQ-018 SHALL, from IDLE with both requests high, go to the requester not named by the last-grant pointer (round-robin).
REQ-019 SHALL, in G0, ignore req0: req1 -> G1, else IDLE; the same requester is never granted on back-to-back cycles.
REQ-020 SHALL, in G1, ignore req1: req0 -> G0, else IDLE.
REQ-021 SHALL update the last-grant pointer to n on every entry into Gn.
REQ-022 SHALL treat a requester as holding req, addr and data stable until it samples its gnt high; it drops or replaces the request the following cycle.
REQ-023 SHALL never assert gnt0 and gnt1 in the same cycle.
REQ-024 SHALL register rdata as bank[raddr] one cycle after raddr is presented.
REQ-025 SHALL, when a read and a write hit the same address on the same edge, return the pre-write (old) value; the new value appears on the next read cycle.
REQ-026 SHALL saturate wr_cnt at 255 with no wrap.
REQ-027 SHALL, on a cycle with clr high, zero all bank entries and wr_cnt at the next edge, force the next state to IDLE, issue no grant and commit no write.
REQ-028 SHALL leave the last-grant pointer unchanged on clr.
REQ-029 SHALL have clr take priority over any pending request.
REQ-030 SHALL leave a request that is pending during clr to be arbitrated normally from IDLE after clr deasserts.

Reset
REQ-031 SHALL, while rst_n is low and regardless of clk, set state IDLE, gnt0 = gnt1 = 0, all bank entries 0, rdata 0 and wr_cnt 0.
REQ-032 SHALL, while rst_n is low, set the last-grant pointer to 1 so requester 0 wins the first tie.
REQ-033 SHALL, on reset mid-grant, drop the grant immediately; that write is either already committed at its edge or not performed.
REQ-034 SHALL deassert reset asynchronously-safe, with the first arbitration on the first rising edge after rst_n goes high.

Structure
REQ-035 SHALL place DATA_W and NUM_REGS defaults, ADDR_W and the FSM state encoding (IDLE, G0, G1) in shared package reg_bank_pkg.
REQ-036 SHALL instantiate sub-module reg_bank for the register array and registered read port, with ports clk, rst_n, clr, we, waddr, wdata, raddr and rdata.
REQ-037 SHALL keep the FSM, round-robin pointer, grant registers and wr_cnt in reg_bank_arb.

Verification
REQ-038 SHALL cover: reset release, req0 = 1, addr0 = 2, data0 = 4'hA -> gnt0 pulses one cycle, bank[2] = 4'hA, wr_cnt = 1.
REQ-039 SHALL cover: req0 and req1 both held from IDLE after reset -> grant order gnt0, gnt1, gnt0, gnt1; never the same requester twice in a row; one-hot grants.
REQ-040 SHALL cover: write bank[1] = 4'h5 with raddr = 1 on the same edge -> rdata shows old 4'h0, then 4'h5 the next cycle.
REQ-041 SHALL cover: clr asserted with req1 pending -> no gnt1 that cycle, bank all 0, wr_cnt = 0; gnt1 occurs the cycle after clr drops.
REQ-042 SHALL cover: 260 single-requester writes -> wr_cnt holds at 255.
REQ-043 SHALL cover: rst_n pulsed low mid-stream between clock edges -> outputs zero immediately, and the first tie after release goes to requester 0.
